ge_tobytes: RTL

//  Compresses an Ed25519 projective point (X:Y:Z) into its 32-byte encoding:
//  s = canonical(Y/Z), with s[255] = parity bit of canonical(X/Z).

---
 rtl/ge_tobytes.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ge_tobytes.sv
// rtl/ge_tobytes.sv - Ed25519 point compression (X:Y:Z) -> 32-byte encoding via Z^(p-2) on a shared multiplier
module ge_tobytes (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   input  logic [319:0] h_x,
   input  logic [319:0] h_y,
   input  logic [319:0] h_z,
   output logic [255:0] s,
   output logic         error,
   output logic         done,
   output logic [319:0] mul_op_a,
   output logic [319:0] mul_op_b,
   output logic         mul_valid,
   input  logic [319:0] mul_res,
   input  logic         mul_done
);

   localparam int FE_W = 320;

   // Inversion exponent p-2 = 2^255 - 21; bit 254 is consumed by loading t=Z.
   localparam logic [254:0] EXP = ~255'd20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ,
      S_MZ,
      S_MX,
      S_MY,
      S_PACK,
      S_DONE
   } state_t;

   // ref10 limb widths alternate 26/25 bits, starting with 26 at limb 0.
   function automatic int limb_w(input int k);
      return (k % 2 == 0) ? 26 : 25;
   endfunction

   // ref10 fe_tobytes freeze: estimate q = floor(h/p) in {0,1}, fold 19*q in, then full carry chain.
   function automatic logic [254:0] fe_freeze(input logic [FE_W-1:0] f);
      logic signed [31:0] h [0:9];
      logic signed [31:0] q;
      logic signed [31:0] c;
      logic [254:0] r;
      int off;
      for (int k = 0; k < 10; k++) h[k] = f[32*k +: 32];
      q = (32'sd19 * h[9] + 32'sd16777216) >>> 25;
      for (int k = 0; k < 10; k++) q = (h[k] + q) >>> limb_w(k);
      h[0] = h[0] + 32'sd19 * q;
      for (int k = 0; k < 9; k++) begin
         c = h[k] >>> limb_w(k);
         h[k+1] = h[k+1] + c;
         h[k] = h[k] - (c <<< limb_w(k));
      end
      // Carry out of limb 9 is 2^255, which is dropped: that is the subtraction of q*p.
      c = h[9] >>> 25;
      h[9] = h[9] - (c <<< 25);
      r = '0;
      off = 0;
      for (int k = 0; k < 10; k++) begin
         r = r | ({223'd0, h[k]} << off);
         off = off + limb_w(k);
      end
      return r;
   endfunction

   // Only the least significant bit of canonical(X/Z) is needed for the sign.
   function automatic logic fe_parity(input logic [FE_W-1:0] f);
      logic [254:0] v;
      v = fe_freeze(f);
      return v[0];
   endfunction

   state_t        state_q, state_d;
   logic [319:0]  x_q, x_d;
   logic [319:0]  y_q, y_d;
   logic [319:0]  z_q, z_d;
   logic [319:0]  t_q, t_d;
   logic [7:0]    i_q, i_d;
   logic          req_q, req_d;
   logic [255:0]  s_q, s_d;
   logic          error_q, error_d;
   logic          done_q, done_d;
   logic          mul_valid_q, mul_valid_d;
   logic [319:0]  mul_op_a_q, mul_op_a_d;
   logic [319:0]  mul_op_b_q, mul_op_b_d;

   logic [254:0]  fy;
   logic [254:0]  ft;
   logic          fx_par;

   assign fy     = fe_freeze(y_q);
   assign ft     = fe_freeze(t_q);
   assign fx_par = fe_parity(x_q);

   assign s         = s_q;
   assign error     = error_q;
   assign done      = done_q;
   assign mul_valid = mul_valid_q;
   assign mul_op_a  = mul_op_a_q;
   assign mul_op_b  = mul_op_b_q;

   // State register and datapath flops; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         t_q         <= '0;
         i_q         <= '0;
         req_q       <= 1'b0;
         s_q         <= '0;
         error_q     <= 1'b0;
         done_q      <= 1'b0;
         mul_valid_q <= 1'b0;
         mul_op_a_q  <= '0;
         mul_op_b_q  <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         t_q         <= t_d;
         i_q         <= i_d;
         req_q       <= req_d;
         s_q         <= s_d;
         error_q     <= error_d;
         done_q      <= done_d;
         mul_valid_q <= mul_valid_d;
         mul_op_a_q  <= mul_op_a_d;
         mul_op_b_q  <= mul_op_b_d;
      end
   end

   // Next-state: each multiply state first issues one request, then waits for mul_done to capture.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      t_d         = t_q;
      i_d         = i_q;
      req_d       = req_q;
      s_d         = s_q;
      error_d     = error_q;
      done_d      = 1'b0;
      mul_valid_d = 1'b0;
      mul_op_a_d  = mul_op_a_q;
      mul_op_b_d  = mul_op_b_q;

      case (state_q)
         S_IDLE: begin
            if (valid) begin
               x_d     = h_x;
               y_d     = h_y;
               z_d     = h_z;
               t_d     = h_z;
               i_d     = 8'd253;
               req_d   = 1'b0;
               state_d = S_SQ;
            end
         end

         S_SQ, S_MZ, S_MX, S_MY: begin
            if (!req_q) begin
               mul_valid_d = 1'b1;
               req_d       = 1'b1;
               case (state_q)
                  S_SQ: begin
                     mul_op_a_d = t_q;
                     mul_op_b_d = t_q;
                  end
                  S_MZ: begin
                     mul_op_a_d = t_q;
                     mul_op_b_d = z_q;
                  end
                  S_MX: begin
                     mul_op_a_d = x_q;
                     mul_op_b_d = t_q;
                  end
                  default: begin
                     mul_op_a_d = y_q;
                     mul_op_b_d = t_q;
                  end
               endcase
            end else if (mul_done) begin
               req_d = 1'b0;
               case (state_q)
                  S_SQ: begin
                     t_d = mul_res;
                     if (EXP[i_q]) begin
                        state_d = S_MZ;
                     end else if (i_q == 8'd0) begin
                        state_d = S_MX;
                     end else begin
                        i_d     = i_q - 8'd1;
                        state_d = S_SQ;
                     end
                  end
                  S_MZ: begin
                     t_d = mul_res;
                     if (i_q == 8'd0) begin
                        state_d = S_MX;
                     end else begin
                        i_d     = i_q - 8'd1;
                        state_d = S_SQ;
                     end
                  end
                  S_MX: begin
                     x_d     = mul_res;
                     state_d = S_MY;
                  end
                  default: begin
                     y_d     = mul_res;
                     state_d = S_PACK;
                  end
               endcase
            end
         end

         S_PACK: begin
            s_d     = {fx_par, fy};
            error_d = (ft == 255'd0);
            done_d  = 1'b1;
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
